// File: rtl/dt_pkg.sv
// Shared constants and enumerations for the distance-transform post-processing stages.
package dt_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int DW     = 8;
    localparam int WORD_W = 16;
    localparam int PIX_N  = IMG_W * IMG_H;
    localparam int AW     = $clog2(PIX_N);
    localparam int CW     = $clog2(IMG_W);
    localparam int BW     = $clog2(WORD_W);
    localparam int SKAW   = AW - BW;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_C = 3'd1,
        ST_RD_N = 3'd2,
        ST_PACK = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        NB_N = 2'd0,
        NB_W = 2'd1,
        NB_E = 2'd2,
        NB_S = 2'd3
    } nbr_e;
endpackage

// File: rtl/dt_nbr_addr.sv
// Maps a pixel index and a 4-neighbour selector to the neighbour address.
// Borders never wrap: an out-of-image neighbour reports in_image=0 and address 0.
module dt_nbr_addr
    import dt_pkg::*;
(
    input  logic [AW-1:0] p_i,
    input  nbr_e          nb_i,
    output logic          in_image_o,
    output logic [AW-1:0] addr_o
);
    logic [CW-1:0]    col_s;
    logic [AW-CW-1:0] row_s;

    assign col_s = p_i[CW-1:0];
    assign row_s = p_i[AW-1:CW];

    // neighbour selection with border suppression
    always_comb begin
        in_image_o = 1'b0;
        addr_o     = '0;
        case (nb_i)
            NB_N: begin
                if (row_s != '0) begin
                    in_image_o = 1'b1;
                    addr_o     = p_i - AW'(IMG_W);
                end else begin
                    in_image_o = 1'b0;
                end
            end
            NB_W: begin
                if (col_s != '0) begin
                    in_image_o = 1'b1;
                    addr_o     = p_i - AW'(1);
                end else begin
                    in_image_o = 1'b0;
                end
            end
            NB_E: begin
                if (col_s != '1) begin
                    in_image_o = 1'b1;
                    addr_o     = p_i + AW'(1);
                end else begin
                    in_image_o = 1'b0;
                end
            end
            NB_S: begin
                if (row_s != '1) begin
                    in_image_o = 1'b1;
                    addr_o     = p_i + AW'(IMG_W);
                end else begin
                    in_image_o = 1'b0;
                end
            end
            default: begin
                in_image_o = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/dt_skeleton.sv
// Scans the distance map and marks local maxima (ties included) as skeleton pixels,
// packing 16 pixels per sk RAM word and counting the marked pixels.
module dt_skeleton
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              res_rd,
    output logic [AW-1:0]     res_addr,
    input  logic [DW-1:0]     res_di,
    output logic              sk_wr,
    output logic [SKAW-1:0]   sk_addr,
    output logic [WORD_W-1:0] sk_do,
    output logic [AW-1:0]     sk_count
);
    state_e              state_q, state_d;
    logic [AW-1:0]       p_q, p_d;
    nbr_e                nb_q, nb_d;
    logic [DW-1:0]       centre_q, centre_d;
    logic                cand_q, cand_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [AW-1:0]       count_q, count_d;
    logic                nb_in_s;
    logic [AW-1:0]       nb_addr_s;

    dt_nbr_addr u_nbr (
        .p_i        (p_q),
        .nb_i       (nb_q),
        .in_image_o (nb_in_s),
        .addr_o     (nb_addr_s)
    );

    assign sk_count = count_q;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            p_q      <= '0;
            nb_q     <= NB_N;
            centre_q <= '0;
            cand_q   <= 1'b0;
            word_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            nb_q     <= nb_d;
            centre_q <= centre_d;
            cand_q   <= cand_d;
            word_q   <= word_d;
            count_q  <= count_d;
        end
    end

    // next-state logic and RAM strobes; addresses/data are zero whenever their strobe is low
    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        nb_d     = nb_q;
        centre_d = centre_q;
        cand_d   = cand_q;
        word_d   = word_q;
        count_d  = count_q;
        busy     = 1'b0;
        done     = 1'b0;
        res_rd   = 1'b0;
        res_addr = '0;
        sk_wr    = 1'b0;
        sk_addr  = '0;
        sk_do    = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    p_d     = '0;
                    nb_d    = NB_N;
                    cand_d  = 1'b0;
                    word_d  = '0;
                    count_d = '0;
                    state_d = ST_RD_C;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_C: begin
                busy     = 1'b1;
                res_rd   = 1'b1;
                res_addr = p_q;
                centre_d = res_di;
                if (res_di == '0) begin
                    cand_d  = 1'b0;
                    state_d = ST_PACK;
                end else begin
                    cand_d  = 1'b1;
                    nb_d    = NB_N;
                    state_d = ST_RD_N;
                end
            end
            ST_RD_N: begin
                busy     = 1'b1;
                res_rd   = nb_in_s;
                res_addr = nb_addr_s;
                if (nb_in_s && (res_di > centre_q)) begin
                    cand_d = 1'b0;
                end else begin
                    cand_d = cand_q;
                end
                if (nb_q == NB_S) begin
                    state_d = ST_PACK;
                end else begin
                    nb_d    = nbr_e'(nb_q + 2'd1);
                    state_d = ST_RD_N;
                end
            end
            ST_PACK: begin
                busy                = 1'b1;
                word_d[p_q[BW-1:0]] = cand_q;
                count_d             = count_q + {{(AW-1){1'b0}}, cand_q};
                if (p_q[BW-1:0] == '1) begin
                    state_d = ST_WR;
                end else begin
                    p_d     = p_q + AW'(1);
                    state_d = ST_RD_C;
                end
            end
            ST_WR: begin
                busy    = 1'b1;
                sk_wr   = 1'b1;
                sk_addr = p_q[AW-1:BW];
                sk_do   = word_q;
                if (p_q == AW'(PIX_N - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    p_d     = p_q + AW'(1);
                    state_d = ST_RD_C;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dt_skeleton.sv
// Scoreboard bench for dt_skeleton: expected sk words are queued at scan start and
// popped by an independent monitor on every sk_wr.
module tb_dt_skeleton;
    import dt_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              done;
    logic              res_rd;
    logic [AW-1:0]     res_addr;
    logic [DW-1:0]     res_di;
    logic              sk_wr;
    logic [SKAW-1:0]   sk_addr;
    logic [WORD_W-1:0] sk_do;
    logic [AW-1:0]     sk_count;

    typedef struct packed {
        logic [SKAW-1:0]   addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    logic [DW-1:0]     mem [0:PIX_N-1];
    logic [WORD_W-1:0] ew  [0:(PIX_N/WORD_W)-1];
    wr_t               exp_q [$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    int                viol_cnt = 0;

    dt_skeleton dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .sk_wr    (sk_wr),
        .sk_addr  (sk_addr),
        .sk_do    (sk_do),
        .sk_count (sk_count)
    );

    assign res_di = mem[res_addr];

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (res_rd) rd_cnt++;
            else if (res_addr != '0) viol_cnt++;
            if (sk_wr) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sk_wr_unexpected: got addr %0d data 0x%0h, expected no write", sk_addr, sk_do);
                end else begin
                    e = exp_q.pop_front();
                    check("sk_word{addr,data}", {38'd0, sk_addr, sk_do}, {38'd0, e.addr, e.data});
                end
            end else if ((sk_addr != '0) || (sk_do != '0)) begin
                viol_cnt++;
            end
        end
    endtask

    task automatic clear_maps();
        for (int i = 0; i < PIX_N; i++) mem[i] = 8'd0;
        for (int i = 0; i < PIX_N / WORD_W; i++) ew[i] = 16'd0;
    endtask

    task automatic push_expected();
        wr_t e;
        for (int i = 0; i < PIX_N / WORD_W; i++) begin
            e.addr = SKAW'(i);
            e.data = ew[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic run_scan(input string nm, input int lat, input int cnt, input int rds, input bit poke);
        int cyc;
        int rd0;
        int v0;
        rd0 = rd_cnt;
        v0  = viol_cnt;
        cyc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (cyc < lat + 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({nm, "_busy"}, {63'd0, busy}, 64'd1);
            if (done) break;
            start = (poke && (cyc == 1000)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({nm, "_done_seen"}, {63'd0, done}, 64'd1);
        check({nm, "_latency"}, 64'(cyc), 64'(lat));
        check({nm, "_sk_count"}, {50'd0, sk_count}, 64'(cnt));
        check({nm, "_res_reads"}, 64'(rd_cnt - rd0), 64'(rds));
        check({nm, "_strobe_gating"}, 64'(viol_cnt - v0), 64'd0);
        check({nm, "_words_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check({nm, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        int cyc;
        int w0;
        int rd0;
        reset = 1'b1;
        start = 1'b0;
        clear_maps();
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", {6'd0, busy, done, res_rd, res_addr, sk_wr, sk_addr, sk_do, sk_count}, 64'd0);

        // combined map: isolated dot, 3x3 plateau, diamond, border/corner pixels
        mem[645] = 8'd1;
        for (int r = 10; r <= 12; r++)
            for (int c = 10; c <= 12; c++) mem[r * IMG_W + c] = 8'd1;
        mem[8256] = 8'd2;
        mem[8128] = 8'd1;
        mem[8255] = 8'd1;
        mem[8257] = 8'd1;
        mem[8384] = 8'd1;
        mem[0]     = 8'd1;
        mem[1]     = 8'd1;
        mem[128]   = 8'd1;
        mem[127]   = 8'd5;
        mem[16256] = 8'd5;
        mem[16383] = 8'd5;
        ew[40]   = 16'h0020;
        ew[80]   = 16'h1C00;
        ew[88]   = 16'h1C00;
        ew[96]   = 16'h1C00;
        ew[516]  = 16'h0001;
        ew[0]    = 16'h0003;
        ew[7]    = 16'h8000;
        ew[8]    = 16'h0001;
        ew[1016] = 16'h0001;
        ew[1023] = 16'h8000;
        push_expected();
        run_scan("pattern_scan", 33876, 17, 16458, 1'b1);

        // all-zero map, reset in the middle of the scan at word 300
        clear_maps();
        push_expected();
        cyc = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (cyc < 12000) begin
            @(negedge clk);
            cyc++;
            if (sk_wr && (sk_addr == 10'd300)) break;
        end
        check("reset_point_reached", {54'd0, sk_addr}, 64'd300);
        reset = 1'b1;
        @(negedge clk);
        check("mid_scan_reset_outputs", {6'd0, busy, done, res_rd, res_addr, sk_wr, sk_addr, sk_do, sk_count}, 64'd0);
        reset = 1'b0;
        exp_q.delete();
        w0  = wr_cnt;
        rd0 = rd_cnt;
        repeat (200) @(negedge clk);
        check("no_sk_wr_after_reset", 64'(wr_cnt - w0), 64'd0);
        check("no_res_rd_after_reset", 64'(rd_cnt - rd0), 64'd0);

        // fresh start on the all-zero map
        push_expected();
        run_scan("zero_scan", 33792, 0, 16384, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
